// File: rtl/prim_ram_1p_pkg.sv
// Purpose: shared types for single-port RAM tuning config and its register-programmed controller.
// Latency: n/a (types, offsets, pack/unpack helpers only).
// Backpressure: n/a.
package prim_ram_1p_pkg;

   // One tuning setting: enable plus 4-bit value.
   typedef struct packed {
      logic       cfg_en;
      logic [3:0] cfg;
   } cfg_t;

   // Full config consumed by prim_ram_1p instances (10 bits, ram_cfg in the upper half).
   typedef struct packed {
      cfg_t ram_cfg;
      cfg_t rf_cfg;
   } ram_1p_cfg_t;

   localparam ram_1p_cfg_t RAM_1P_CFG_DEFAULT = '0;

   // Word offsets of the controller register port.
   localparam logic [1:0] CfgPendingOffset = 2'd0;
   localparam logic [1:0] CfgActiveOffset  = 2'd1;
   localparam logic [1:0] CfgCtrlOffset    = 2'd2;

   // CTRL register bit positions.
   localparam int unsigned CtrlCommitBit = 0;
   localparam int unsigned CtrlDoneBit   = 1;
   localparam int unsigned CtrlBusyBit   = 2;

   typedef enum logic [2:0] {
      StIdle,
      StQuiesce,
      StApply,
      StSettle,
      StRelease
   } cfg_ctrl_state_e;

   // Register layout: ram_cfg in [4:0], rf_cfg in [12:8], everything else zero.
   function automatic logic [31:0] ram_1p_cfg_pack(input ram_1p_cfg_t c);
      return {19'b0, c.rf_cfg, 3'b0, c.ram_cfg};
   endfunction

   function automatic ram_1p_cfg_t ram_1p_cfg_unpack(input logic [31:0] w);
      ram_1p_cfg_t c;
      c.ram_cfg = w[4:0];
      c.rf_cfg  = w[12:8];
      return c;
   endfunction

endpackage

// File: rtl/prim_ram_1p_cfg_regs.sv
// Purpose: register decode, PENDING/DONE storage and response pipeline of the RAM config controller.
// Latency: every granted access answers with rvalid exactly one cycle later.
// Backpressure: none; grant mirrors request, so one access can be accepted every cycle.
//
// Ports: reg_* = request/grant register port; active_cfg_i/busy_i = status from the FSM;
// done_set_i = apply sequence finished; pending_cfg_o = PENDING contents;
// commit_o = accepted commit (only ever asserted while not busy).
module prim_ram_1p_cfg_regs
   import prim_ram_1p_pkg::*;
#(
   parameter ram_1p_cfg_t CfgDefault = RAM_1P_CFG_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        reg_req_i,
   input  logic        reg_we_i,
   input  logic [1:0]  reg_addr_i,
   input  logic [31:0] reg_wdata_i,
   output logic        reg_gnt_o,
   output logic        reg_rvalid_o,
   output logic [31:0] reg_rdata_o,
   output logic        reg_err_o,
   input  ram_1p_cfg_t active_cfg_i,
   input  logic        busy_i,
   input  logic        done_set_i,
   output ram_1p_cfg_t pending_cfg_o,
   output logic        commit_o
);

   ram_1p_cfg_t pending_q;
   logic        done_q;
   logic        rvalid_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic        pend_we;
   logic        done_clr;
   logic        commit;
   logic        err_d;
   logic [31:0] rdata_d;

   assign reg_gnt_o = reg_req_i;

   always_comb begin
      pend_we  = 1'b0;
      done_clr = 1'b0;
      commit   = 1'b0;
      err_d    = 1'b0;
      rdata_d  = '0;
      if (reg_req_i) begin
         unique case (reg_addr_i)
            CfgPendingOffset: begin
               if (reg_we_i) pend_we = 1'b1;
               else          rdata_d = ram_1p_cfg_pack(pending_q);
            end
            CfgActiveOffset: begin
               if (reg_we_i) err_d   = 1'b1;
               else          rdata_d = ram_1p_cfg_pack(active_cfg_i);
            end
            CfgCtrlOffset: begin
               if (reg_we_i) begin
                  // A refused commit discards the whole word, including any DONE clear.
                  if (reg_wdata_i[CtrlCommitBit] && busy_i) begin
                     err_d = 1'b1;
                  end else begin
                     commit   = reg_wdata_i[CtrlCommitBit];
                     done_clr = reg_wdata_i[CtrlDoneBit];
                  end
               end else begin
                  rdata_d[CtrlDoneBit] = done_q;
                  rdata_d[CtrlBusyBit] = busy_i;
               end
            end
            default: err_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_q <= CfgDefault;
         done_q    <= 1'b0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         rvalid_q <= reg_req_i;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         if (pend_we) pending_q <= ram_1p_cfg_unpack(reg_wdata_i);
         // Completion of a sequence wins over a simultaneous clear.
         done_q <= (done_q & ~done_clr) | done_set_i;
      end
   end

   assign reg_rvalid_o  = rvalid_q;
   assign reg_err_o     = err_q;
   assign reg_rdata_o   = rdata_q;
   assign pending_cfg_o = pending_q;
   assign commit_o      = commit;

endmodule

// File: rtl/prim_ram_1p_cfg_ctrl.sv
// Purpose: owns the active RAM tuning config; applies a committed value under a quiesce handshake.
// Latency: commit -> quiesce_req next cycle; new ram_cfg_o two cycles after ack is first seen high.
// Backpressure: commits while busy are refused with err; the FSM waits on quiesce_ack_i indefinitely.
//
// Ports: clk_i/rst_i (sync, active-high); reg_* register port (gnt = req, response one cycle later);
// quiesce_req_o/quiesce_ack_i handshake with the memories; ram_cfg_o active config; busy_o = not IDLE.
// SettleCycles must lie in 1..15 (4-bit settle counter).
module prim_ram_1p_cfg_ctrl
   import prim_ram_1p_pkg::*;
#(
   parameter int unsigned SettleCycles = 4,
   parameter ram_1p_cfg_t CfgDefault   = RAM_1P_CFG_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        reg_req_i,
   input  logic        reg_we_i,
   input  logic [1:0]  reg_addr_i,
   input  logic [31:0] reg_wdata_i,
   output logic        reg_gnt_o,
   output logic        reg_rvalid_o,
   output logic [31:0] reg_rdata_o,
   output logic        reg_err_o,
   output logic        quiesce_req_o,
   input  logic        quiesce_ack_i,
   output ram_1p_cfg_t ram_cfg_o,
   output logic        busy_o
);

   localparam logic [3:0] SettleLoad = 4'(SettleCycles - 1);

   cfg_ctrl_state_e state_q, state_d;
   logic [3:0]      cnt_q;
   ram_1p_cfg_t     staged_q;
   ram_1p_cfg_t     active_q;
   ram_1p_cfg_t     pending_cfg;
   logic            commit;
   logic            done_set;
   logic            quiesce_req;

   prim_ram_1p_cfg_regs #(
      .CfgDefault (CfgDefault)
   ) u_regs (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .reg_req_i     (reg_req_i),
      .reg_we_i      (reg_we_i),
      .reg_addr_i    (reg_addr_i),
      .reg_wdata_i   (reg_wdata_i),
      .reg_gnt_o     (reg_gnt_o),
      .reg_rvalid_o  (reg_rvalid_o),
      .reg_rdata_o   (reg_rdata_o),
      .reg_err_o     (reg_err_o),
      .active_cfg_i  (active_q),
      .busy_i        (busy_o),
      .done_set_i    (done_set),
      .pending_cfg_o (pending_cfg),
      .commit_o      (commit)
   );

   // Quiesce stays asserted from the first QUIESCE cycle through the last SETTLE cycle.
   always_comb begin
      state_d     = state_q;
      quiesce_req = 1'b0;
      done_set    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (commit) state_d = StQuiesce;
         end
         StQuiesce: begin
            quiesce_req = 1'b1;
            if (quiesce_ack_i) state_d = StApply;
         end
         StApply: begin
            quiesce_req = 1'b1;
            state_d     = StSettle;
         end
         StSettle: begin
            quiesce_req = 1'b1;
            if (cnt_q == 4'd0) state_d = StRelease;
         end
         StRelease: begin
            if (!quiesce_ack_i) begin
               done_set = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         staged_q <= CfgDefault;
         active_q <= CfgDefault;
      end else begin
         state_q <= state_d;
         if (commit) staged_q <= pending_cfg;
         if (state_q == StApply) begin
            active_q <= staged_q;
            cnt_q    <= SettleLoad;
         end else if (state_q == StSettle && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   assign quiesce_req_o = quiesce_req;
   assign ram_cfg_o     = active_q;
   assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_prim_ram_1p_cfg_ctrl.sv
// Purpose: directed self-checking bench for prim_ram_1p_cfg_ctrl (default settle and SettleCycles=1).
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: all waits on the DUT are bounded.
module tb_prim_ram_1p_cfg_ctrl;
   import prim_ram_1p_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_req, reg_we, reg_gnt, reg_rvalid, reg_err, q_req, q_ack, busy;
   logic [1:0]  reg_addr;
   logic [31:0] reg_wdata, reg_rdata;
   ram_1p_cfg_t ram_cfg;

   logic        req2, we2, gnt2, rvalid2, err2, q_req2, q_ack2, busy2;
   logic [1:0]  addr2;
   logic [31:0] wdata2, rdata2;
   ram_1p_cfg_t ram_cfg2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prim_ram_1p_cfg_ctrl u_dut (
      .clk_i (clk), .rst_i (rst),
      .reg_req_i (reg_req), .reg_we_i (reg_we), .reg_addr_i (reg_addr), .reg_wdata_i (reg_wdata),
      .reg_gnt_o (reg_gnt), .reg_rvalid_o (reg_rvalid), .reg_rdata_o (reg_rdata), .reg_err_o (reg_err),
      .quiesce_req_o (q_req), .quiesce_ack_i (q_ack), .ram_cfg_o (ram_cfg), .busy_o (busy)
   );

   prim_ram_1p_cfg_ctrl #(.SettleCycles (1)) u_dut_s1 (
      .clk_i (clk), .rst_i (rst),
      .reg_req_i (req2), .reg_we_i (we2), .reg_addr_i (addr2), .reg_wdata_i (wdata2),
      .reg_gnt_o (gnt2), .reg_rvalid_o (rvalid2), .reg_rdata_o (rdata2), .reg_err_o (err2),
      .quiesce_req_o (q_req2), .quiesce_ack_i (q_ack2), .ram_cfg_o (ram_cfg2), .busy_o (busy2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic reg_acc(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
      reg_req   = 1'b1;
      reg_we    = we;
      reg_addr  = addr;
      reg_wdata = wdata;
      #1;
      check("gnt", 32'(reg_gnt), 32'd1);
      @(posedge clk);
      #1;
      reg_req = 1'b0;
      reg_we  = 1'b0;
      check("rvalid", 32'(reg_rvalid), 32'd1);
      rdata = reg_rdata;
      err   = reg_err;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          qcnt;
      int          n;

      rst = 1'b1; reg_req = 0; reg_we = 0; reg_addr = 0; reg_wdata = 0; q_ack = 0;
      req2 = 0; we2 = 0; addr2 = 0; wdata2 = 0; q_ack2 = 1'b1;
      repeat (3) tick;
      rst = 1'b0;
      tick;

      // Reset state
      check("rst_ram_cfg", 32'(ram_cfg), 32'h0);
      check("rst_qreq", 32'(q_req), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rvalid", 32'(reg_rvalid), 32'h0);
      check("rst_err", 32'(reg_err), 32'h0);
      check("rst_rdata", reg_rdata, 32'h0);

      reg_acc(1'b0, CfgActiveOffset, 32'h0, rd, er);
      check("active_rst_rdata", rd, 32'h0);
      check("active_rst_err", 32'(er), 32'h0);
      tick;
      check("rvalid_single", 32'(reg_rvalid), 32'h0);

      // PENDING keeps only its defined fields
      reg_acc(1'b1, CfgPendingOffset, 32'hFFFF_FFFF, rd, er);
      reg_acc(1'b0, CfgPendingOffset, 32'h0, rd, er);
      check("pending_mask", rd, 32'h0000_1F1F);

      // Full apply sequence: 3 cycles QUIESCE, 1 APPLY, 4 SETTLE
      reg_acc(1'b1, CfgPendingOffset, 32'h0000_1A15, rd, er);
      reg_acc(1'b1, CfgCtrlOffset, 32'h1, rd, er);
      check("commit_err", 32'(er), 32'h0);
      check("commit_qreq", 32'(q_req), 32'h1);
      check("commit_busy", 32'(busy), 32'h1);
      qcnt = 1;
      tick; if (q_req) qcnt++;
      tick; if (q_req) qcnt++;
      q_ack = 1'b1;
      tick; if (q_req) qcnt++;
      check("cfg_hold_in_apply", 32'(ram_cfg), 32'h0);
      tick; if (q_req) qcnt++;
      check("cfg_applied", 32'(ram_cfg), 32'h2BA);
      n = 0;
      while (n < 20) begin
         tick;
         if (!q_req) break;
         qcnt++;
         n++;
      end
      check("qreq_len", 32'(qcnt), 32'd8);
      check("release_busy", 32'(busy), 32'h1);
      q_ack = 1'b0;
      tick;
      check("idle_busy", 32'(busy), 32'h0);
      reg_acc(1'b0, CfgCtrlOffset, 32'h0, rd, er);
      check("ctrl_done", rd, 32'h2);
      reg_acc(1'b0, CfgActiveOffset, 32'h0, rd, er);
      check("active_rd", rd, 32'h0000_1A15);

      // Commit plus DONE clear in one word, then refused commit during SETTLE
      reg_acc(1'b1, CfgPendingOffset, 32'h0000_0F07, rd, er);
      reg_acc(1'b1, CfgCtrlOffset, 32'h3, rd, er);
      check("commit_clr_err", 32'(er), 32'h0);
      reg_acc(1'b0, CfgCtrlOffset, 32'h0, rd, er);
      check("ctrl_busy_noclr", rd, 32'h4);
      q_ack = 1'b1;
      tick;
      tick;
      check("cfg_applied2", 32'(ram_cfg), 32'h0EF);
      reg_acc(1'b1, CfgPendingOffset, 32'h3, rd, er);
      check("pend_wr_settle_err", 32'(er), 32'h0);
      reg_acc(1'b1, CfgCtrlOffset, 32'h1, rd, er);
      check("busy_commit_err", 32'(er), 32'h1);
      check("busy_commit_cfg", 32'(ram_cfg), 32'h0EF);
      n = 0;
      while (q_req && n < 20) begin tick; n++; end
      check("qreq_drop2", 32'(q_req), 32'h0);
      q_ack = 1'b0;
      tick;
      check("idle_busy2", 32'(busy), 32'h0);
      check("cfg_kept", 32'(ram_cfg), 32'h0EF);
      reg_acc(1'b0, CfgPendingOffset, 32'h0, rd, er);
      check("pending_settle_wr", rd, 32'h3);
      reg_acc(1'b0, CfgCtrlOffset, 32'h0, rd, er);
      check("ctrl_done2", rd, 32'h2);

      // Error accesses
      reg_acc(1'b0, 2'd3, 32'h0, rd, er);
      check("addr3_rd_err", 32'(er), 32'h1);
      check("addr3_rd_data", rd, 32'h0);
      reg_acc(1'b1, 2'd3, 32'hFFFF_FFFF, rd, er);
      check("addr3_wr_err", 32'(er), 32'h1);
      reg_acc(1'b1, CfgActiveOffset, 32'h0000_FFFF, rd, er);
      check("active_wr_err", 32'(er), 32'h1);
      check("active_wr_data", rd, 32'h0);
      reg_acc(1'b0, CfgActiveOffset, 32'h0, rd, er);
      check("active_unchanged", rd, 32'h0000_0F07);
      check("err_no_busy", 32'(busy), 32'h0);

      // Reset in SETTLE, with an access in flight
      reg_acc(1'b1, CfgCtrlOffset, 32'h1, rd, er);
      q_ack = 1'b1;
      tick;
      tick;
      check("cfg_applied3", 32'(ram_cfg), 32'h060);
      rst = 1'b1; reg_req = 1'b1; reg_we = 1'b0; reg_addr = CfgActiveOffset;
      tick;
      reg_req = 1'b0;
      check("rst_mid_qreq", 32'(q_req), 32'h0);
      check("rst_mid_cfg", 32'(ram_cfg), 32'h0);
      check("rst_mid_busy", 32'(busy), 32'h0);
      check("rst_mid_rvalid", 32'(reg_rvalid), 32'h0);
      rst = 1'b0; q_ack = 1'b0;
      tick;
      reg_acc(1'b0, CfgPendingOffset, 32'h0, rd, er);
      check("rst_mid_pending", rd, 32'h0);
      reg_acc(1'b0, CfgCtrlOffset, 32'h0, rd, er);
      check("rst_mid_ctrl", rd, 32'h0);

      // SettleCycles=1 with ack already high at commit
      req2 = 1'b1; we2 = 1'b1; addr2 = CfgPendingOffset; wdata2 = 32'h0000_1A15;
      tick;
      addr2 = CfgCtrlOffset; wdata2 = 32'h1;
      tick;
      req2 = 1'b0; we2 = 1'b0;
      check("s1_quiesce_qreq", 32'(q_req2), 32'h1);
      tick;
      check("s1_apply_qreq", 32'(q_req2), 32'h1);
      check("s1_apply_cfg", 32'(ram_cfg2), 32'h0);
      tick;
      check("s1_settle_qreq", 32'(q_req2), 32'h1);
      check("s1_settle_cfg", 32'(ram_cfg2), 32'h2BA);
      tick;
      check("s1_release_qreq", 32'(q_req2), 32'h0);
      check("s1_release_busy", 32'(busy2), 32'h1);
      q_ack2 = 1'b0;
      tick;
      check("s1_idle_busy", 32'(busy2), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
